// File: rtl/led_disp_pkg.sv
// Shared constants, converter state encoding and the active-low 7-segment
// encoder for the 4-digit LED display controller.
package led_disp_pkg;

    localparam logic [3:0] BLANK = 4'hF;
    localparam logic [3:0] DASH  = 4'hE;

    localparam logic [1:0] SEL_DIN = 2'b00;
    localparam logic [1:0] SEL_MS  = 2'b01;
    localparam logic [1:0] SEL_RES = 2'b10;
    localparam logic [1:0] SEL_OFF = 2'b11;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        LOAD   = 2'b00,
        SHIFT  = 2'b01,
        UPDATE = 2'b10
    } conv_state_e;

    // Segments are {g,f,e,d,c,b,a}; a 0 lights the segment.
    function automatic logic [6:0] seg_encode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            DASH:    s = 7'h3F;
            BLANK:   s = 7'h7F;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_display_ctrl_if.sv
// Bus between the calculator control logic (master) and the LED display
// controller (slave): display selection, operands and the display pins.
interface led_display_ctrl_if #(
    parameter int BIN_W = 14
);
    logic [1:0]       LEDsel;
    logic [BIN_W-1:0] din;
    logic [2:0]       MS;
    logic [BIN_W-1:0] result;
    logic [3:0]       an;
    logic [6:0]       seg;
    logic             dp;

    modport master (
        output LEDsel, din, MS, result,
        input  an, seg, dp
    );

    modport slave (
        input  LEDsel, din, MS, result,
        output an, seg, dp
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: LOAD, BIN_W shift cycles,
// one UPDATE cycle where bcd/ovf are valid and done is high.
module bin2bcd_seq
    import led_disp_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             CLK,
    input  logic             clear,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic [15:0]      bcd,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_e      state_r;
    conv_state_e      state_nxt_s;
    logic [BIN_W-1:0] bin_r;
    logic [15:0]      bcd_r;
    logic [15:0]      bcd_adj_s;
    logic             ovf_r;
    logic [CNT_W-1:0] cnt_r;

    function automatic logic [15:0] add3_all(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Converter state register.
    always_ff @(posedge CLK) begin
        if (clear) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Converter next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD:    state_nxt_s = start ? SHIFT : LOAD;
            SHIFT:   state_nxt_s = (cnt_r == CNT_W'(BIN_W - 1)) ? UPDATE : SHIFT;
            UPDATE:  state_nxt_s = LOAD;
            default: state_nxt_s = LOAD;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            LOAD: begin
                busy = 1'b0;
                done = 1'b0;
            end
            SHIFT: begin
                busy = 1'b1;
                done = 1'b0;
            end
            UPDATE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Nibble correction applied before every shift.
    always_comb begin
        bcd_adj_s = add3_all(bcd_r);
    end

    // Conversion datapath; overflow is judged on the binary input so that
    // values whose BCD form exceeds 16 bits cannot fool it.
    always_ff @(posedge CLK) begin
        if (clear) begin
            bin_r <= '0;
            bcd_r <= 16'h0000;
            ovf_r <= 1'b0;
            cnt_r <= '0;
        end else begin
            case (state_r)
                LOAD: begin
                    if (start) begin
                        bin_r <= bin_in;
                        bcd_r <= 16'h0000;
                        ovf_r <= (32'(bin_in) > 32'd9999);
                        cnt_r <= '0;
                    end
                end
                SHIFT: begin
                    {bcd_r, bin_r} <= {bcd_adj_s, bin_r} << 1;
                    cnt_r          <= cnt_r + CNT_W'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bcd = bcd_r;
    assign ovf = ovf_r;

endmodule

// File: rtl/led_display_ctrl.sv
// 4-digit multiplexed active-low 7-segment display controller: selects a
// value, converts it to decimal digits and scans the digits onto the anodes.
module led_display_ctrl
    import led_disp_pkg::*;
#(
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 100000
) (
    input logic              CLK,
    input logic              clear,
    led_display_ctrl_if.slave bus
);

    localparam int TICK_W = $clog2(REFRESH_DIV);

    logic [BIN_W-1:0]  val_s;
    logic [1:0]        sel_r;
    logic [15:0]       bcd_s;
    logic              ovf_s;
    logic              busy_s;
    logic              done_s;
    logic [3:0]        d_r     [4];
    logic [3:0]        d_nxt_s [4];
    logic [TICK_W-1:0] tick_r;
    logic [1:0]        idx_r;
    logic [3:0]        an_r;
    logic [6:0]        seg_r;
    logic              dp_r;

    // Value presented to the converter, chosen by the live LEDsel.
    always_comb begin
        val_s = '0;
        case (bus.LEDsel)
            SEL_DIN: val_s = bus.din;
            SEL_MS:  val_s = BIN_W'(bus.MS);
            SEL_RES: val_s = bus.result;
            SEL_OFF: val_s = '0;
            default: val_s = '0;
        endcase
    end

    bin2bcd_seq #(
        .BIN_W (BIN_W)
    ) u_conv (
        .CLK    (CLK),
        .clear  (clear),
        .start  (1'b1),
        .bin_in (val_s),
        .bcd    (bcd_s),
        .ovf    (ovf_s),
        .busy   (busy_s),
        .done   (done_s)
    );

    // LEDsel is latched in the same cycle the converter loads its value.
    always_ff @(posedge CLK) begin
        if (clear) begin
            sel_r <= SEL_OFF;
        end else if (!busy_s) begin
            sel_r <= bus.LEDsel;
        end else begin
            sel_r <= sel_r;
        end
    end

    // Digit codes from the finished conversion, with leading-zero blanking.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            d_nxt_s[k] = BLANK;
        end
        if (sel_r == SEL_OFF) begin
            for (int k = 0; k < 4; k++) begin
                d_nxt_s[k] = BLANK;
            end
        end else if (ovf_s) begin
            for (int k = 0; k < 4; k++) begin
                d_nxt_s[k] = DASH;
            end
        end else if (sel_r == SEL_MS) begin
            d_nxt_s[0] = bcd_s[3:0];
        end else begin
            d_nxt_s[3] = (bcd_s[15:12] == 4'h0)  ? BLANK : bcd_s[15:12];
            d_nxt_s[2] = (bcd_s[15:8]  == 8'h00) ? BLANK : bcd_s[11:8];
            d_nxt_s[1] = (bcd_s[15:4]  == 12'h000) ? BLANK : bcd_s[7:4];
            d_nxt_s[0] = bcd_s[3:0];
        end
    end

    // Digit registers, written only on the converter's UPDATE cycle.
    always_ff @(posedge CLK) begin
        if (clear) begin
            for (int k = 0; k < 4; k++) begin
                d_r[k] <= BLANK;
            end
        end else if (done_s) begin
            for (int k = 0; k < 4; k++) begin
                d_r[k] <= d_nxt_s[k];
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                d_r[k] <= d_r[k];
            end
        end
    end

    // Refresh tick and scan index; idx wraps 3 -> 0 by its own width.
    always_ff @(posedge CLK) begin
        if (clear) begin
            tick_r <= '0;
            idx_r  <= 2'd0;
        end else if (tick_r == TICK_W'(REFRESH_DIV - 1)) begin
            tick_r <= '0;
            idx_r  <= idx_r + 2'd1;
        end else begin
            tick_r <= tick_r + TICK_W'(1);
            idx_r  <= idx_r;
        end
    end

    // Registered display pins; digits are re-read every cycle.
    always_ff @(posedge CLK) begin
        if (clear) begin
            an_r  <= 4'hF;
            seg_r <= SEG_OFF;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= ~(4'b0001 << idx_r);
            seg_r <= seg_encode(d_r[idx_r]);
            dp_r  <= 1'b1;
        end
    end

    assign bus.an  = an_r;
    assign bus.seg = seg_r;
    assign bus.dp  = dp_r;

endmodule

// File: tb/tb_led_display_ctrl.sv
// Scoreboard bench for led_display_ctrl: stimulus pushes expected scan
// windows from a decimal reference model, a monitor checks each anode step.
module tb_led_display_ctrl;

    localparam int BIN_W       = 14;
    localparam int REFRESH_DIV = 4;
    localparam int PERIOD      = BIN_W + 2;
    localparam int ROTATION    = 4 * REFRESH_DIV;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic CLK   = 1'b0;
    logic clear = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    led_display_ctrl_if #(.BIN_W(BIN_W)) bus ();

    led_display_ctrl #(
        .BIN_W       (BIN_W),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .CLK   (CLK),
        .clear (clear),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Cycles since clear was last released.
    always @(posedge CLK) begin
        if (clear) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Expected segment pattern of digit k (0 = rightmost) from decimal arithmetic.
    function automatic logic [6:0] model_seg(int sel, int v, int k);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (sel == 3) return 7'h7F;
        if (v > 9999) return 7'h3F;
        if (sel == 1) return (k == 0) ? seg_tab[v] : 7'h7F;
        if (k == 0 || v >= p) return seg_tab[(v / p) % 10];
        return 7'h7F;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_pins(input string name);
        check_eq({name, "_an"},  32'(bus.an),  32'hF);
        check_eq({name, "_seg"}, 32'(bus.seg), 32'h7F);
        check_eq({name, "_dp"},  32'(bus.dp),  32'h1);
    endtask

    task automatic check_blank_window(input string name);
        for (int n = 1; n < PERIOD; n++) begin
            @(negedge CLK);
            check_eq(name, 32'(bus.seg), 32'h7F);
        end
    endtask

    // Drive one display request, let it settle, then queue one full scan rotation.
    task automatic apply(input int sel, input int val);
        int   v;
        exp_t e;
        @(negedge CLK);
        bus.din    = BIN_W'($urandom_range(0, 16383));
        bus.MS     = 3'($urandom_range(0, 7));
        bus.result = BIN_W'($urandom_range(0, 16383));
        case (sel)
            0:       bus.din    = BIN_W'(val);
            1:       bus.MS     = 3'(val);
            2:       bus.result = BIN_W'(val);
            default: bus.din    = bus.din;
        endcase
        bus.LEDsel = 2'(sel);
        case (sel)
            0:       v = int'(bus.din);
            1:       v = int'(bus.MS);
            2:       v = int'(bus.result);
            default: v = 0;
        endcase
        repeat (2 * PERIOD + 2) @(negedge CLK);
        for (int n = 0; n < ROTATION && (cyc % ROTATION) != 0; n++) @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            e.an  = 4'(~(4'b0001 << k));
            e.seg = model_seg(sel, v, k);
            exp_q.push_back(e);
        end
        for (int n = 0; n < 2 * ROTATION && exp_q.size() > 0; n++) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scan_timeout: %0d windows not seen, expected 0 left", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every anode step pops one expected window and checks it.
    initial begin
        logic [3:0] prev_an;
        int         win_len;
        exp_t       e;
        prev_an = 4'hF;
        win_len = 0;
        forever begin
            @(negedge CLK);
            if (bus.an !== prev_an) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (bus.an !== e.an || bus.seg !== e.seg) begin
                        errors++;
                        $display("FAIL scan_digit: an=%b seg=%h, expected an=%b seg=%h",
                                 bus.an, bus.seg, e.an, e.seg);
                    end
                    checks++;
                    if (win_len != REFRESH_DIV) begin
                        errors++;
                        $display("FAIL window_len: got %0d cycles, expected %0d", win_len, REFRESH_DIV);
                    end
                end
                win_len = 1;
            end else begin
                win_len++;
            end
            prev_an = bus.an;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int dir_sel [12] = '{2, 0, 0, 2, 2, 1, 3, 0, 2, 2, 1, 0};
        int dir_val [12] = '{1234, 7, 0, 10000, 16383, 5, 0, 9876, 9999, 1005, 0, 60};
        int sel;
        int val;

        bus.LEDsel = 2'b00;
        bus.din    = '0;
        bus.MS     = 3'd0;
        bus.result = '0;
        clear      = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_pins("reset");
        clear = 1'b0;
        check_blank_window("blank_before_update");

        for (int i = 0; i < 12; i++) apply(dir_sel[i], dir_val[i]);

        // Abort a conversion in flight: change result mid-SHIFT, clear on UPDATE.
        apply(2, 1234);
        for (int n = 0; n < PERIOD && (cyc % PERIOD) != 4; n++) @(negedge CLK);
        bus.result = BIN_W'(4321);
        for (int n = 0; n < PERIOD && (cyc % PERIOD) != PERIOD - 1; n++) @(negedge CLK);
        clear = 1'b1;
        @(negedge CLK);
        check_reset_pins("clear_abort");
        clear = 1'b0;
        check_blank_window("blank_after_clear");
        apply(2, 4321);

        for (int i = 0; i < 6; i++) begin
            sel = int'($urandom_range(0, 3));
            if (sel == 1)                    val = int'($urandom_range(0, 7));
            else if ($urandom_range(0, 1) == 0) val = int'($urandom_range(0, 9999));
            else                             val = int'($urandom_range(0, 16383));
            apply(sel, val);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
